// File: rtl/stream_select_pkg.sv
// stream_select_pkg: shared state encoding and sizing helper for the stream select block
package stream_select_pkg;

   // Occupancy of the output register + skid register pair
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   // Index width for n candidates, never narrower than one bit
   function automatic int sel_bits(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/select_rows_3d_array.sv
// select_rows_3d_array: per-row choice between two candidate arrays, zeroing rows with a bad index
module select_rows_3d_array
   import stream_select_pkg::*;
#(
   parameter int BIT_WIDTH  = 4,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int NUM_INPUTS = 4,
   localparam int SEL_WIDTH = sel_bits(NUM_INPUTS)
) (
   input  logic [BIT_WIDTH-1:0] in_data [NUM_INPUTS][ROWS][COLS],
   input  logic [ROWS-1:0]      row_cond,
   input  logic [SEL_WIDTH-1:0] sel_true,
   input  logic [SEL_WIDTH-1:0] sel_false,
   output logic [BIT_WIDTH-1:0] out_data [ROWS][COLS],
   output logic                 err
);

   logic [SEL_WIDTH-1:0] idx [ROWS];

   // Each row picks its source; an index with no matching candidate leaves the row zero
   always_comb begin
      err = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         idx[r] = row_cond[r] ? sel_true : sel_false;
         err = err | (int'(idx[r]) >= NUM_INPUTS);
         for (int c = 0; c < COLS; c++) begin
            out_data[r][c] = '0;
            for (int i = 0; i < NUM_INPUTS; i++)
               if (int'(idx[r]) == i) out_data[r][c] = in_data[i][r][c];
         end
      end
   end

endmodule

// File: rtl/stream_select_3d_array.sv
// stream_select_3d_array: row-selecting array stream with an output register and one skid register
module stream_select_3d_array
   import stream_select_pkg::*;
#(
   parameter int BIT_WIDTH  = 4,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int NUM_INPUTS = 4,
   localparam int SEL_WIDTH = sel_bits(NUM_INPUTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_data [NUM_INPUTS][ROWS][COLS],
   input  logic [SEL_WIDTH-1:0] sel_true,
   input  logic [SEL_WIDTH-1:0] sel_false,
   input  logic [ROWS-1:0]      row_cond,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out_data [ROWS][COLS],
   output logic                 out_sel_err,
   output logic                 sel_err_sticky
);

   state_t               state, state_nxt;
   logic                 push, pop, load_out, load_skid;
   logic                 sel_err, skid_err;
   logic [BIT_WIDTH-1:0] sel_data  [ROWS][COLS];
   logic [BIT_WIDTH-1:0] skid_data [ROWS][COLS];

   select_rows_3d_array #(
      .BIT_WIDTH (BIT_WIDTH),
      .ROWS      (ROWS),
      .COLS      (COLS),
      .NUM_INPUTS(NUM_INPUTS)
   ) u_sel (
      .in_data  (in_data),
      .row_cond (row_cond),
      .sel_true (sel_true),
      .sel_false(sel_false),
      .out_data (sel_data),
      .err      (sel_err)
   );

   // Ready depends only on occupancy, so there is no path from in_valid
   assign in_ready  = (state != TWO) && !rst;
   assign out_valid = state != EMPTY;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Next occupancy and which register captures this cycle
   always_comb begin
      state_nxt = state;
      load_out  = 1'b0;
      load_skid = 1'b0;
      case (state)
         EMPTY: begin
            state_nxt = push ? ONE : EMPTY;
            load_out  = push;
         end
         ONE: begin
            state_nxt = (push && !pop) ? TWO : (!push && pop) ? EMPTY : ONE;
            load_out  = push && pop;
            load_skid = push && !pop;
         end
         TWO: begin
            state_nxt = pop ? ONE : TWO;
            load_out  = pop;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Occupancy register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Output and skid storage; in TWO the output refills from the skid to keep order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data       <= '{default: '0};
         out_sel_err    <= 1'b0;
         skid_data      <= '{default: '0};
         skid_err       <= 1'b0;
         sel_err_sticky <= 1'b0;
      end else begin
         if (load_out) begin
            if (state == TWO) begin
               out_data    <= skid_data;
               out_sel_err <= skid_err;
            end else begin
               out_data    <= sel_data;
               out_sel_err <= sel_err;
            end
         end
         if (load_skid) begin
            skid_data <= sel_data;
            skid_err  <= sel_err;
         end
         if (push && sel_err) sel_err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_select_3d_array.sv
// tb_stream_select_3d_array: directed checks of selection, handshake, error flags and reset
module tb_stream_select_3d_array;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         total = 0;
   int         bad = 0;

   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, out_sel_err, sticky;
   logic [3:0] in_data [4][8][8];
   logic [1:0] sel_true = '0, sel_false = '0;
   logic [7:0] row_cond = '0;
   logic [3:0] out_data [8][8];

   logic       in_valid3 = 1'b0, out_ready3 = 1'b0;
   logic       in_ready3, out_valid3, out_sel_err3, sticky3;
   logic [3:0] in_data3 [3][8][8];
   logic [1:0] sel_true3 = '0, sel_false3 = '0;
   logic [7:0] row_cond3 = '0;
   logic [3:0] out_data3 [8][8];

   always #5 clk = ~clk;

   stream_select_3d_array u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sel_true(sel_true), .sel_false(sel_false), .row_cond(row_cond),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sel_err(out_sel_err), .sel_err_sticky(sticky)
   );

   stream_select_3d_array #(.NUM_INPUTS(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .sel_true(sel_true3), .sel_false(sel_false3), .row_cond(row_cond3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .out_sel_err(out_sel_err3), .sel_err_sticky(sticky3)
   );

   // Element value of candidate i for beat tag
   function automatic logic [3:0] ev(input int tag, input int i, input int r, input int c);
      return 4'(tag * 7 + i * 4 + r + c * 2);
   endfunction

   task automatic fill(input int tag);
      for (int i = 0; i < 4; i++) for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++)
         in_data[i][r][c] = ev(tag, i, r, c);
   endtask

   task automatic fill3(input int tag);
      for (int i = 0; i < 3; i++) for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++)
         in_data3[i][r][c] = ev(tag, i, r, c);
   endtask

   // Number of elements of a that differ from the expected selection; n=0 expects all zeros
   function automatic int arr_errs(input logic [3:0] a [8][8], input int n, input int tag,
                                   input int st, input int sf, input logic [7:0] cond);
      int e, s;
      logic [3:0] x;
      e = 0;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         s = cond[r] ? st : sf;
         x = (s >= n) ? 4'h0 : ev(tag, s, r, c);
         if (a[r][c] !== x) e++;
      end
      return e;
   endfunction

   task automatic beat(input int tag, input int st, input int sf, input logic [7:0] cond);
      fill(tag);
      sel_true  = 2'(st);
      sel_false = 2'(sf);
      row_cond  = cond;
      in_valid  = 1'b1;
   endtask

   task automatic test_reset;
      int e;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      total++; if (sticky !== 1'b0 || sticky3 !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b/%b want 0/0", sticky, sticky3); end
      e = arr_errs(out_data, 0, 0, 0, 0, 8'h00);
      total++; if (e !== 0) begin bad++; $display("FAIL reset_out_data: %0d nonzero elements, want 0", e); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic;
      int e;
      out_ready = 1'b1;
      beat(1, 2, 1, 8'hF0);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      e = arr_errs(out_data, 4, 1, 2, 1, 8'hF0);
      total++; if (e !== 0) begin bad++; $display("FAIL basic_data: %0d elements wrong, want 0", e); end
      total++; if (out_sel_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", out_sel_err); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_stall;
      int e;
      out_ready = 1'b0;
      beat(2, 0, 3, 8'h0F);
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL stall_one: valid/ready %b/%b want 1/1", out_valid, in_ready); end
      beat(3, 1, 1, 8'hAA);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full: in_ready %b want 0", in_ready); end
      beat(4, 3, 2, 8'h55);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_c_refused: in_ready %b want 0", in_ready); end
      e = arr_errs(out_data, 4, 2, 0, 3, 8'h0F);
      total++; if (e !== 0) begin bad++; $display("FAIL stall_a_stable: %0d elements wrong, want 0", e); end
      out_ready = 1'b1;
      @(negedge clk);
      e = arr_errs(out_data, 4, 3, 1, 1, 8'hAA);
      total++; if (e !== 0 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_b_out: %0d elements wrong valid=%b, want 0 and 1", e, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_reopen: in_ready %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      e = arr_errs(out_data, 4, 4, 3, 2, 8'h55);
      total++; if (e !== 0 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_c_out: %0d elements wrong valid=%b, want 0 and 1", e, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      int e;
      out_ready = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            e = arr_errs(out_data, 4, 16 + k - 1, (k - 1) % 4, k % 4, 8'((k - 1) * 37));
            total++; if (e !== 0 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_beat%0d: %0d elements wrong valid=%b, want 0 and 1", k - 1, e, out_valid); end
         end
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
         if (k < 16) beat(16 + k, k % 4, (k + 1) % 4, 8'(k * 37));
         else in_valid = 1'b0;
         @(negedge clk);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_sel_err;
      int e;
      out_ready3 = 1'b1;
      fill3(5);
      sel_true3 = 2'd3; sel_false3 = 2'd0; row_cond3 = 8'h01; in_valid3 = 1'b1;
      @(negedge clk);
      e = arr_errs(out_data3, 3, 5, 3, 0, 8'h01);
      total++; if (e !== 0 || out_valid3 !== 1'b1) begin bad++; $display("FAIL err_data: %0d elements wrong valid=%b, want 0 and 1", e, out_valid3); end
      total++; if (out_sel_err3 !== 1'b1) begin bad++; $display("FAIL err_flag: got %b want 1", out_sel_err3); end
      total++; if (sticky3 !== 1'b1) begin bad++; $display("FAIL err_sticky_set: got %b want 1", sticky3); end
      fill3(6);
      sel_true3 = 2'd1; sel_false3 = 2'd2;
      @(negedge clk);
      in_valid3 = 1'b0;
      e = arr_errs(out_data3, 3, 6, 1, 2, 8'h01);
      total++; if (e !== 0 || out_sel_err3 !== 1'b0) begin bad++; $display("FAIL err_clean_beat: %0d elements wrong err=%b, want 0 and 0", e, out_sel_err3); end
      @(negedge clk);
      total++; if (sticky3 !== 1'b1 || out_valid3 !== 1'b0) begin bad++; $display("FAIL err_sticky_hold: sticky=%b valid=%b want 1 and 0", sticky3, out_valid3); end
      total++; if (sticky !== 1'b0) begin bad++; $display("FAIL err_four_inputs_clean: sticky %b want 0", sticky); end
   endtask

   task automatic test_reset_mid;
      int e;
      out_ready = 1'b0;
      beat(40, 0, 1, 8'h3C);
      @(negedge clk);
      beat(41, 2, 3, 8'hC3);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_two: ready/valid %b/%b want 0/1", in_ready, out_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || out_sel_err !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: valid/err %b/%b want 0/0", out_valid, out_sel_err); end
      total++; if (sticky3 !== 1'b0 || sticky !== 1'b0) begin bad++; $display("FAIL mid_rst_sticky: %b/%b want 0/0", sticky, sticky3); end
      e = arr_errs(out_data, 0, 0, 0, 0, 8'h00);
      total++; if (e !== 0) begin bad++; $display("FAIL mid_rst_data: %0d nonzero elements, want 0", e); end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      beat(42, 3, 0, 8'h81);
      @(negedge clk);
      in_valid = 1'b0;
      e = arr_errs(out_data, 4, 42, 3, 0, 8'h81);
      total++; if (e !== 0 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_after_beat: %0d elements wrong valid=%b, want 0 and 1", e, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_stale: valid %b want 0", out_valid); end
   endtask

   initial begin
      fill(0);
      fill3(0);
      test_reset;
      test_basic;
      test_stall;
      test_back_to_back;
      test_sel_err;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_select_3d_array.md
STREAM_SELECT_3D_ARRAY -- requirements
Module: stream_select_3d_array

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, element width in bits.
REQ-002 SHALL have parameter ROWS, default 8, array rows.
REQ-003 SHALL have parameter COLS, default 8, array columns.
REQ-004 SHALL have parameter NUM_INPUTS, default 4, number of candidate arrays (>=2).
REQ-005 SHALL derive localparam SEL_WIDTH = $clog2(NUM_INPUTS), minimum 1.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port in_valid  input  1  upstream beat valid.
REQ-009 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-010 SHALL have port in_data  input  [BIT_WIDTH-1:0] [NUM_INPUTS][ROWS][COLS]  candidate arrays.
REQ-011 SHALL have port sel_true  input  SEL_WIDTH  source index for rows whose condition is 1.
REQ-012 SHALL have port sel_false  input  SEL_WIDTH  source index for rows whose condition is 0.
REQ-013 SHALL have port row_cond  input  ROWS  per-row condition.
REQ-014 SHALL have port out_valid  output  1  result beat valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts.
REQ-016 SHALL have port out_data  output  [BIT_WIDTH-1:0] [ROWS][COLS]  selected array.
REQ-017 SHALL have port out_sel_err  output  1  beat flag: an out-of-range index was used.
REQ-018 SHALL have port sel_err_sticky  output  1  any accepted beat ever flagged.

Function
REQ-019 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-020 At input transfer, result row r SHALL be in_data[row_cond[r] ? sel_true : sel_false][r][*], sampled that cycle.
REQ-021 If the index applied to row r is >= NUM_INPUTS, row r SHALL be all zeros and the beat's err flag 1; other rows unaffected.
REQ-022 Storage SHALL be an output register plus one skid register; states EMPTY, ONE, TWO.
REQ-023 in_ready SHALL equal (state != TWO) && !rst, independent of in_valid and out_ready.
REQ-024 EMPTY: accept -> ONE, output register loaded; out_valid rises next cycle (latency 1).
REQ-025 ONE: accept with pop -> ONE, output reloaded; accept only -> TWO, skid loaded; pop only -> EMPTY; neither -> ONE.
REQ-026 TWO: pop -> ONE, output register loaded from skid; no pop -> TWO.
REQ-027 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-028 out_data and out_sel_err SHALL hold stable while out_valid && !out_ready.
REQ-029 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-030 Sustained in_valid=out_ready=1 SHALL give one beat per cycle.
REQ-031 sel_err_sticky SHALL set the cycle after accepting a flagged beat and clear only on reset.
REQ-032 sel_true == sel_false SHALL behave as whole-array select, ignoring row_cond.

Reset
REQ-033 rst assertion SHALL immediately force state EMPTY, out_valid 0, out_data all zeros, out_sel_err 0, sel_err_sticky 0, skid contents zero.
REQ-034 Beats held at rst SHALL be discarded; no output transfer in the cycle rst deasserts.

Structure
REQ-035 State enum (EMPTY, ONE, TWO) SHALL live in the shared package stream_select_pkg.
REQ-036 Row selection SHALL be sub-module select_rows_3d_array (combinational, NUM_INPUTS arrays + row_cond + two indices -> array + err).
REQ-037 Handshake and storage SHALL be in stream_select_3d_array; no latches, no combinational path from in_valid to in_ready.

Verification
REQ-038 Reset, then one beat, sel_true=2, sel_false=1, row_cond=8'hF0, out_ready=1 -> out_valid next cycle; rows 4-7 = in_data[2], rows 0-3 = in_data[1].
REQ-039 out_ready=0, three beats A,B,C offered -> A,B accepted, in_ready=0 on C; release out_ready -> A,B,C out in order, data stable while stalled.
REQ-040 NUM_INPUTS=3, sel_true=3, row_cond=8'h01 -> row 0 zeros, out_sel_err=1, sel_err_sticky=1 thereafter; next clean beat out_sel_err=0.
REQ-041 Back-to-back 16 beats with out_ready=1 -> 16 outputs on 16 consecutive cycles, in_ready constant 1.
REQ-042 rst asserted mid-cycle in state TWO -> out_valid, sticky flags 0 immediately; subsequent beat emerges with latency 1.
